trace_request_queue: RTL and testbench
======================================

# trace_request_queue

Receives decoded CPU memory requests from the trace front end and releases each one into the memory controller at its trace timestamp. It sits between the trace parser and the DDR5 scheduler. It keeps the simulated CPU cycle counter and buffers pending requests in a 16-entry in-order queue. When nothing is pending, it advances time directly to the next request's timestamp.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 36, physical byte address width
- CPU_CORE_WIDTH, 4, requesting core ID width
- MEM_OPN_WIDTH, 3, operation code width
- TIME_WIDTH, 64, CPU cycle counter and timestamp width
- QUEUE_DEPTH, 16, queue entries (power of two, ≥2)

Ports:
- clk  in  1  CPU clock; one clock domain for the whole block
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  request from parser is present
- in_ready  out  1  block accepts request this cycle
- in_time  in  TIME_WIDTH  request arrival time (CPU cycles)
- in_core  in  CPU_CORE_WIDTH  core ID
- in_opn  in  MEM_OPN_WIDTH  operation code
- in_addr  in  MEM_ADDR_WIDTH  address
- out_valid  out  1  queue head valid
- out_ready  in  1  controller takes head
- out_time, out_core, out_opn, out_addr  out  widths as inputs  head entry fields
- cur_time  out  TIME_WIDTH  current CPU cycle
- q_count  out  $clog2(QUEUE_DEPTH)+1  occupancy
- q_full  out  1  q_count == QUEUE_DEPTH
- err_opn  out  1  one-cycle pulse: invalid op dropped

## Operation
- Valid ops: 0 READ, 1 WRITE, 2 IFETCH. Codes 3–7 are invalid.
- Input handshake is in_valid && in_ready.
  - A valid-op request loads a one-entry stage register.
  - An invalid-op request is consumed and discarded. err_opn is high the following cycle. Nothing is staged.
- in_ready = !stage_valid || stage_enq. The stage can refill in the same cycle it drains.
- stage_enq = stage_valid && (cur_time >= stage_time) && (q_count < QUEUE_DEPTH || deq). deq = out_valid && out_ready.
  - Comparison is unsigned.
  - A full queue with a simultaneous dequeue still accepts the enqueue.
- cur_time per edge:
  - Skip: if stage_valid && q_count == 0 && cur_time < stage_time, then cur_time ← stage_time.
  - Otherwise cur_time ← cur_time + 1, wrapping mod 2^TIME_WIDTH.
  - Trace timestamps must be monotonic and must not wrap. Out-of-order timestamps (older than cur_time) are enqueued immediately.
- Queue:
  - Strict FIFO. The head is presented on out_* while out_valid is high.
  - out_* are stable while out_valid && !out_ready.
  - Simultaneous enq/deq leaves q_count unchanged.
- Reset (async, any time) clears all state immediately:
  - in_ready 0 while rst_n low, 1 from the first edge after release
  - out_valid 0, out_* 0
  - cur_time 0, q_count 0, q_full 0, err_opn 0
  - In-flight entries are lost.

## Timing
- Eligible request (time ≤ cur_time), empty queue: handshake at edge E0, staged at E0, enqueued at E1, out_valid high after E1. Latency is 2 edges.
- Future request, empty queue: handshake at E0. At E1, cur_time jumps to in_time. Enqueue at E2, out_valid after E2.
- Future request, non-empty queue: no skip. Enqueue at the first edge where the pre-edge cur_time ≥ stage_time.
- Sustained throughput is one request per cycle in and one per cycle out.
- Dequeue at edge E frees the slot. A blocked stage enqueues at the same edge E.
- err_opn is exactly one cycle wide per invalid request. Back-to-back invalid requests give consecutive pulses.

## Structure
- ddr5_mc_pkg:
  - mem_opn_e enum (READ, WRITE, IFETCH)
  - cpu_req_t packed struct (time, core, opn, addr)
  - parameter defaults shared with the parser and scheduler
- Sub-module req_fifo: synchronous FIFO of cpu_req_t.
  - Registered head output.
  - Ports for push, pop, count and full; supports simultaneous push/pop when full.
- The top level holds the stage register, time counter and op check.

## Test plan
- After reset: READ, time 0, core 3, addr 0x0_1234_5678 → out_valid 2 edges after handshake; out_core 3, out_opn 0, out_addr 0x012345678, out_time 0.
- cur_time 5, queue empty; request time 1000 → cur_time = 1000 one edge later; out_valid the next edge; out_time 1000.
- Queue holds 1 entry (out_ready=0), cur_time 10; request time 14 → no skip; enqueued on the edge where pre-edge cur_time = 14; q_count 2.
- out_ready=0; 18 requests at time 0 → q_count 16, q_full 1; stage holds the 17th; in_ready 0. One dequeue → 17th enqueued the same edge; q_count stays 16; in_ready 1.
- in_opn = 5 → err_opn high for 1 cycle; q_count unchanged; next valid request accepted normally.
- 3 entries queued, cur_time 50; rst_n low mid-cycle → out_valid, q_count, cur_time read 0 immediately; after release the queue is empty and counting restarts from 0.

Source files
------------

// File: rtl/ddr5_mc_pkg.sv
// Types and default widths shared by the trace parser, request queue and DDR5 scheduler.
package ddr5_mc_pkg;

   localparam int DEF_MEM_ADDR_WIDTH = 36;
   localparam int DEF_CPU_CORE_WIDTH = 4;
   localparam int DEF_MEM_OPN_WIDTH  = 3;
   localparam int DEF_TIME_WIDTH     = 64;
   localparam int DEF_QUEUE_DEPTH    = 16;

   typedef enum logic [DEF_MEM_OPN_WIDTH-1:0] {
      OPN_READ   = 3'd0,
      OPN_WRITE  = 3'd1,
      OPN_IFETCH = 3'd2
   } mem_opn_e;

   typedef struct packed {
      logic [DEF_TIME_WIDTH-1:0]     req_time;
      logic [DEF_CPU_CORE_WIDTH-1:0] core;
      logic [DEF_MEM_OPN_WIDTH-1:0]  opn;
      logic [DEF_MEM_ADDR_WIDTH-1:0] addr;
   } cpu_req_t;

endpackage

// File: rtl/req_fifo.sv
// In-order request FIFO with a registered head entry; accepts a push while full
// provided the head is popped in the same cycle.
module req_fifo
   import ddr5_mc_pkg::*;
#(
   parameter type T     = cpu_req_t,
   parameter int  DEPTH = DEF_QUEUE_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  T                         i_push_data,
   input  logic                     i_pop,
   output T                         o_head,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   T                 r_mem [DEPTH];
   T                 r_head;
   T                 w_head_next;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] w_rd_ptr_inc;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;
   logic             w_push;

   assign o_full       = (r_count == CNT_W'(DEPTH));
   assign o_valid      = (r_count != '0);
   assign o_count      = r_count;
   assign o_head       = r_head;
   assign w_pop        = i_pop && o_valid;
   assign w_push       = i_push && (!o_full || w_pop);
   assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

   // The head register always mirrors the entry that will be at r_rd_ptr after the edge.
   always_comb begin
      w_head_next = r_head;
      if (w_pop) begin
         if (r_count > CNT_W'(1))
            w_head_next = r_mem[w_rd_ptr_inc];
         else if (w_push)
            w_head_next = i_push_data;
         else
            w_head_next = '0;
      end else if (w_push && (r_count == '0)) begin
         w_head_next = i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         r_head <= w_head_next;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= w_rd_ptr_inc;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/trace_request_queue.sv
// Releases trace requests to the memory controller at their timestamp; owns the
// CPU cycle counter, the one-entry stage register and the opcode check.
module trace_request_queue
   import ddr5_mc_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
   parameter int CPU_CORE_WIDTH = DEF_CPU_CORE_WIDTH,
   parameter int MEM_OPN_WIDTH  = DEF_MEM_OPN_WIDTH,
   parameter int TIME_WIDTH     = DEF_TIME_WIDTH,
   parameter int QUEUE_DEPTH    = DEF_QUEUE_DEPTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [TIME_WIDTH-1:0]          in_time,
   input  logic [CPU_CORE_WIDTH-1:0]      in_core,
   input  logic [MEM_OPN_WIDTH-1:0]       in_opn,
   input  logic [MEM_ADDR_WIDTH-1:0]      in_addr,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [TIME_WIDTH-1:0]          out_time,
   output logic [CPU_CORE_WIDTH-1:0]      out_core,
   output logic [MEM_OPN_WIDTH-1:0]       out_opn,
   output logic [MEM_ADDR_WIDTH-1:0]      out_addr,
   output logic [TIME_WIDTH-1:0]          cur_time,
   output logic [$clog2(QUEUE_DEPTH):0]   q_count,
   output logic                           q_full,
   output logic                           err_opn
);

   typedef struct packed {
      logic [TIME_WIDTH-1:0]     req_time;
      logic [CPU_CORE_WIDTH-1:0] core;
      logic [MEM_OPN_WIDTH-1:0]  opn;
      logic [MEM_ADDR_WIDTH-1:0] addr;
   } req_t;

   req_t                  r_stage;
   req_t                  w_in_req;
   req_t                  w_head;
   logic                  r_stage_valid;
   logic                  r_ready_en;
   logic                  r_err_opn;
   logic [TIME_WIDTH-1:0] r_cur_time;
   logic                  w_head_valid;
   logic                  w_full;
   logic                  w_deq;
   logic                  w_stage_enq;
   logic                  w_in_fire;
   logic                  w_opn_ok;
   logic                  w_skip;

   assign w_in_req    = '{req_time: in_time, core: in_core, opn: in_opn, addr: in_addr};
   assign w_opn_ok    = (in_opn <= MEM_OPN_WIDTH'(OPN_IFETCH));
   assign w_deq       = w_head_valid && out_ready;
   assign w_stage_enq = r_stage_valid && (r_cur_time >= r_stage.req_time) && (!w_full || w_deq);
   // r_ready_en keeps in_ready low until the first edge after reset release.
   assign in_ready    = r_ready_en && (!r_stage_valid || w_stage_enq);
   assign w_in_fire   = in_valid && in_ready;
   assign w_skip      = r_stage_valid && (q_count == '0) && (r_cur_time < r_stage.req_time);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage       <= '0;
         r_stage_valid <= 1'b0;
         r_ready_en    <= 1'b0;
         r_err_opn     <= 1'b0;
         r_cur_time    <= '0;
      end else begin
         r_ready_en <= 1'b1;
         r_err_opn  <= w_in_fire && !w_opn_ok;
         if (w_in_fire && w_opn_ok) begin
            r_stage       <= w_in_req;
            r_stage_valid <= 1'b1;
         end else if (w_stage_enq) begin
            r_stage_valid <= 1'b0;
         end
         // With nothing pending, jump straight to the staged request's timestamp.
         if (w_skip)
            r_cur_time <= r_stage.req_time;
         else
            r_cur_time <= r_cur_time + TIME_WIDTH'(1);
      end
   end

   req_fifo #(
      .T     (req_t),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_stage_enq),
      .i_push_data (r_stage),
      .i_pop       (out_ready),
      .o_head      (w_head),
      .o_valid     (w_head_valid),
      .o_count     (q_count),
      .o_full      (w_full)
   );

   assign out_valid = w_head_valid;
   assign out_time  = w_head.req_time;
   assign out_core  = w_head.core;
   assign out_opn   = w_head.opn;
   assign out_addr  = w_head.addr;
   assign cur_time  = r_cur_time;
   assign q_full    = w_full;
   assign err_opn   = r_err_opn;

endmodule

// File: tb/tb_trace_request_queue.sv
// Directed bench for trace_request_queue: reset, release latency, time skip,
// blocked future request, full queue, invalid opcodes and mid-cycle reset.
module tb_trace_request_queue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_time;
   logic [3:0]  in_core;
   logic [2:0]  in_opn;
   logic [35:0] in_addr;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_time;
   logic [3:0]  out_core;
   logic [2:0]  out_opn;
   logic [35:0] out_addr;
   logic [63:0] cur_time;
   logic [4:0]  q_count;
   logic        q_full;
   logic        err_opn;

   int n_pass  = 0;
   int n_total = 0;

   trace_request_queue dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_time   (in_time),
      .in_core   (in_core),
      .in_opn    (in_opn),
      .in_addr   (in_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_time  (out_time),
      .out_core  (out_core),
      .out_opn   (out_opn),
      .out_addr  (out_addr),
      .cur_time  (cur_time),
      .q_count   (q_count),
      .q_full    (q_full),
      .err_opn   (err_opn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT one edge past release: cur_time 1, in_ready 1.
   task automatic apply_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Returns 1 ns after the handshake edge.
   task automatic send_req(input logic [63:0] t, input logic [3:0] c,
                           input logic [2:0] o, input logic [35:0] a);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_time  = t;
      in_core  = c;
      in_opn   = o;
      in_addr  = a;
      for (int i = 0; i < 40 && !done; i++) begin
         #1;
         if (in_ready)
            done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      n_total++;
      if (!done)
         $display("FAIL send_timeout: in_ready never seen for addr %0h", a);
      else
         n_pass++;
   endtask

   task automatic test_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_time   = '0;
      in_core   = '0;
      in_opn    = '0;
      in_addr   = '0;
      rst_n     = 1'b0;
      tick();
      tick();
      n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else n_pass++;
      n_total++; if (cur_time !== 64'd0) $display("FAIL rst_cur_time: got %0d want 0", cur_time); else n_pass++;
      n_total++; if (q_count !== 5'd0) $display("FAIL rst_q_count: got %0d want 0", q_count); else n_pass++;
      n_total++; if (q_full !== 1'b0) $display("FAIL rst_q_full: got %0b want 0", q_full); else n_pass++;
      n_total++; if (err_opn !== 1'b0) $display("FAIL rst_err_opn: got %0b want 0", err_opn); else n_pass++;
      n_total++; if (out_addr !== 36'd0) $display("FAIL rst_out_addr: got %0h want 0", out_addr); else n_pass++;
      rst_n = 1'b1;
      #1;
      n_total++; if (in_ready !== 1'b0) $display("FAIL rel_in_ready_pre: got %0b want 0", in_ready); else n_pass++;
      @(posedge clk);
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready_post: got %0b want 1", in_ready); else n_pass++;
      n_total++; if (cur_time !== 64'd1) $display("FAIL rel_cur_time: got %0d want 1", cur_time); else n_pass++;
   endtask

   task automatic test_basic();
      apply_reset();
      send_req(64'd0, 4'd3, 3'd0, 36'h0_1234_5678);
      n_total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_e0: got %0b want 0", out_valid); else n_pass++;
      tick();
      n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid_e1: got %0b want 1", out_valid); else n_pass++;
      n_total++; if (out_core !== 4'd3) $display("FAIL basic_core: got %0d want 3", out_core); else n_pass++;
      n_total++; if (out_opn !== 3'd0) $display("FAIL basic_opn: got %0d want 0", out_opn); else n_pass++;
      n_total++; if (out_addr !== 36'h0_1234_5678) $display("FAIL basic_addr: got %0h want 12345678", out_addr); else n_pass++;
      n_total++; if (out_time !== 64'd0) $display("FAIL basic_time: got %0d want 0", out_time); else n_pass++;
      n_total++; if (q_count !== 5'd1) $display("FAIL basic_count: got %0d want 1", q_count); else n_pass++;
      tick();
      n_total++; if (out_addr !== 36'h0_1234_5678) $display("FAIL basic_hold: got %0h want 12345678", out_addr); else n_pass++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_total++; if (out_valid !== 1'b0) $display("FAIL basic_drained: got %0b want 0", out_valid); else n_pass++;
      n_total++; if (q_count !== 5'd0) $display("FAIL basic_count_0: got %0d want 0", q_count); else n_pass++;
   endtask

   task automatic test_skip();
      apply_reset();
      tick();
      tick();
      tick();
      send_req(64'd1000, 4'd1, 3'd1, 36'h100);
      n_total++; if (cur_time !== 64'd5) $display("FAIL skip_pre: got %0d want 5", cur_time); else n_pass++;
      tick();
      n_total++; if (cur_time !== 64'd1000) $display("FAIL skip_jump: got %0d want 1000", cur_time); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL skip_valid_e1: got %0b want 0", out_valid); else n_pass++;
      tick();
      n_total++; if (out_valid !== 1'b1) $display("FAIL skip_valid_e2: got %0b want 1", out_valid); else n_pass++;
      n_total++; if (out_time !== 64'd1000) $display("FAIL skip_out_time: got %0d want 1000", out_time); else n_pass++;
      n_total++; if (cur_time !== 64'd1001) $display("FAIL skip_post: got %0d want 1001", cur_time); else n_pass++;
   endtask

   task automatic test_no_skip();
      apply_reset();
      send_req(64'd0, 4'd2, 3'd0, 36'h200);
      tick();
      n_total++; if (q_count !== 5'd1) $display("FAIL noskip_first: got %0d want 1", q_count); else n_pass++;
      for (int i = 0; i < 6; i++)
         tick();
      send_req(64'd14, 4'd2, 3'd1, 36'h214);
      n_total++; if (cur_time !== 64'd10) $display("FAIL noskip_t10: got %0d want 10", cur_time); else n_pass++;
      tick();
      n_total++; if (cur_time !== 64'd11) $display("FAIL noskip_t11: got %0d want 11", cur_time); else n_pass++;
      tick();
      tick();
      tick();
      n_total++; if (q_count !== 5'd1) $display("FAIL noskip_wait: got %0d want 1", q_count); else n_pass++;
      n_total++; if (cur_time !== 64'd14) $display("FAIL noskip_t14: got %0d want 14", cur_time); else n_pass++;
      tick();
      n_total++; if (q_count !== 5'd2) $display("FAIL noskip_enq: got %0d want 2", q_count); else n_pass++;
      n_total++; if (out_time !== 64'd0) $display("FAIL noskip_head: got %0d want 0", out_time); else n_pass++;
      out_ready = 1'b1;
      tick();
      n_total++; if (out_time !== 64'd14) $display("FAIL noskip_second: got %0d want 14", out_time); else n_pass++;
      n_total++; if (out_addr !== 36'h214) $display("FAIL noskip_addr: got %0h want 214", out_addr); else n_pass++;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_full();
      apply_reset();
      for (int i = 0; i < 17; i++)
         send_req(64'd0, 4'(i), 3'd0, 36'(i));
      in_valid = 1'b1;
      in_time  = 64'd0;
      in_core  = 4'd1;
      in_opn   = 3'd1;
      in_addr  = 36'd17;
      tick();
      tick();
      n_total++; if (q_count !== 5'd16) $display("FAIL full_count: got %0d want 16", q_count); else n_pass++;
      n_total++; if (q_full !== 1'b1) $display("FAIL full_flag: got %0b want 1", q_full); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %0b want 0", in_ready); else n_pass++;
      out_ready = 1'b1;
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL full_in_ready_deq: got %0b want 1", in_ready); else n_pass++;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_total++; if (q_count !== 5'd16) $display("FAIL full_count_deq: got %0d want 16", q_count); else n_pass++;
      n_total++; if (q_full !== 1'b1) $display("FAIL full_flag_deq: got %0b want 1", q_full); else n_pass++;
      n_total++; if (out_addr !== 36'd1) $display("FAIL full_head: got %0d want 1", out_addr); else n_pass++;
      out_ready = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         n_total++;
         if (out_valid !== 1'b1 || out_addr !== 36'(k))
            $display("FAIL full_drain_%0d: got valid %0b addr %0d want valid 1 addr %0d", k, out_valid, out_addr, k);
         else
            n_pass++;
         tick();
      end
      out_ready = 1'b0;
      n_total++; if (q_count !== 5'd0) $display("FAIL full_empty: got %0d want 0", q_count); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL full_empty_valid: got %0b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_err_opn();
      apply_reset();
      send_req(64'd0, 4'd4, 3'd1, 36'h400);
      tick();
      n_total++; if (q_count !== 5'd1) $display("FAIL err_setup: got %0d want 1", q_count); else n_pass++;
      send_req(64'd0, 4'd4, 3'd5, 36'h405);
      n_total++; if (err_opn !== 1'b1) $display("FAIL err_pulse: got %0b want 1", err_opn); else n_pass++;
      n_total++; if (q_count !== 5'd1) $display("FAIL err_count: got %0d want 1", q_count); else n_pass++;
      tick();
      n_total++; if (err_opn !== 1'b0) $display("FAIL err_width: got %0b want 0", err_opn); else n_pass++;
      send_req(64'd0, 4'd4, 3'd3, 36'h403);
      n_total++; if (err_opn !== 1'b1) $display("FAIL err_b2b_1: got %0b want 1", err_opn); else n_pass++;
      send_req(64'd0, 4'd4, 3'd7, 36'h407);
      n_total++; if (err_opn !== 1'b1) $display("FAIL err_b2b_2: got %0b want 1", err_opn); else n_pass++;
      send_req(64'd0, 4'd4, 3'd2, 36'hABC);
      n_total++; if (err_opn !== 1'b0) $display("FAIL err_ifetch: got %0b want 0", err_opn); else n_pass++;
      tick();
      n_total++; if (q_count !== 5'd2) $display("FAIL err_after: got %0d want 2", q_count); else n_pass++;
      out_ready = 1'b1;
      n_total++; if (out_opn !== 3'd1) $display("FAIL err_head_opn: got %0d want 1", out_opn); else n_pass++;
      tick();
      n_total++; if (out_opn !== 3'd2 || out_addr !== 36'hABC) $display("FAIL err_second: got opn %0d addr %0h want opn 2 addr abc", out_opn, out_addr); else n_pass++;
      tick();
      out_ready = 1'b0;
      n_total++; if (q_count !== 5'd0) $display("FAIL err_drained: got %0d want 0", q_count); else n_pass++;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      send_req(64'd0, 4'd5, 3'd0, 36'h501);
      send_req(64'd0, 4'd5, 3'd0, 36'h502);
      send_req(64'd0, 4'd5, 3'd0, 36'h503);
      tick();
      for (int i = 0; i < 45; i++)
         tick();
      n_total++; if (cur_time !== 64'd50) $display("FAIL rmid_time: got %0d want 50", cur_time); else n_pass++;
      n_total++; if (q_count !== 5'd3) $display("FAIL rmid_count: got %0d want 3", q_count); else n_pass++;
      #3;
      rst_n = 1'b0;
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %0b want 0", out_valid); else n_pass++;
      n_total++; if (q_count !== 5'd0) $display("FAIL rmid_count0: got %0d want 0", q_count); else n_pass++;
      n_total++; if (cur_time !== 64'd0) $display("FAIL rmid_time0: got %0d want 0", cur_time); else n_pass++;
      n_total++; if (out_addr !== 36'd0) $display("FAIL rmid_addr0: got %0h want 0", out_addr); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %0b want 0", in_ready); else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
      n_total++; if (cur_time !== 64'd1) $display("FAIL rmid_restart: got %0d want 1", cur_time); else n_pass++;
      n_total++; if (out_valid !== 1'b0 || q_count !== 5'd0) $display("FAIL rmid_empty: got valid %0b count %0d want 0 0", out_valid, q_count); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL rmid_ready: got %0b want 1", in_ready); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skip();
      test_no_skip();
      test_full();
      test_err_opn();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
